regfile_wb_arbiter: RTL and testbench

- Owns the single write port of the integer register file and shares it between two writeback requesters: EXU results (req 0) and LSU load data (req 1).
- Keeps a per-register busy scoreboard. The issue stage reserves a destination here and gets RAW/WAW hazard flags for its two source registers.
- Sits between the EXU/LSU writeback stages and the register file write port. Its rf_* outputs drive the file's wen/waddr/wdata directly.

---
 rtl/regfile_wb_arbiter_pkg.sv | 9 +
 rtl/regfile_wb_arbiter_rr_arb2.sv | 35 +++
 rtl/regfile_wb_arbiter.sv | 105 ++++++++++
 tb/tb_regfile_wb_arbiter.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants for the register-file writeback arbiter: default widths,
// the hard-wired zero register and the requester indices.
package regfile_wb_arbiter_pkg;
    localparam int DEF_ADDR_WIDTH = 5;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int ZERO_REG       = 0;
    localparam int REQ_EXU        = 0;
    localparam int REQ_LSU        = 1;
endpackage

// File: rtl/regfile_wb_arbiter_rr_arb2.sv
// Two-way round-robin arbiter; a contended cycle goes to the requester named
// by prio_r, and after every grant the other requester becomes favoured.
module rr_arb2
    import regfile_wb_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] gnt
);
    logic prio_r;

    // Lone requester wins outright; contention resolved by prio_r.
    always_comb begin
        gnt = 2'b00;
        if (req == 2'b11) begin
            gnt[prio_r] = 1'b1;
        end else begin
            gnt = req;
        end
    end

    // Any grant is a handshake, so favour the requester that was not granted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio_r <= 1'(REQ_EXU);
        end else if (gnt[REQ_EXU]) begin
            prio_r <= 1'(REQ_LSU);
        end else if (gnt[REQ_LSU]) begin
            prio_r <= 1'(REQ_EXU);
        end else begin
            prio_r <= prio_r;
        end
    end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port between EXU and LSU writebacks and keeps
// the per-register busy scoreboard used by issue for RAW/WAW detection.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wb0_valid,
    output logic                  wb0_ready,
    input  logic [ADDR_WIDTH-1:0] wb0_addr,
    input  logic [DATA_WIDTH-1:0] wb0_data,
    input  logic                  wb1_valid,
    output logic                  wb1_ready,
    input  logic [ADDR_WIDTH-1:0] wb1_addr,
    input  logic [DATA_WIDTH-1:0] wb1_data,
    input  logic                  rsv_valid,
    input  logic [ADDR_WIDTH-1:0] rsv_addr,
    output logic                  rsv_ready,
    input  logic [ADDR_WIDTH-1:0] rs1_addr,
    input  logic [ADDR_WIDTH-1:0] rs2_addr,
    output logic                  rs1_busy,
    output logic                  rs2_busy,
    output logic                  rf_wen,
    output logic [ADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata
);
    localparam int NREG = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(ZERO_REG);

    logic [1:0]            gnt_s;
    logic                  hs_s;
    logic [ADDR_WIDTH-1:0] sel_addr_s;
    logic [DATA_WIDTH-1:0] sel_data_s;
    logic                  rsv_fire_s;
    logic [NREG-1:0]       set_mask_s;
    logic [NREG-1:0]       clr_mask_s;
    logic [NREG-1:0]       busy_next_s;
    logic [NREG-1:0]       busy_r;

    rr_arb2 u_arb (
        .clk (clk),
        .rst (rst),
        .req ({wb1_valid, wb0_valid}),
        .gnt (gnt_s)
    );

    assign wb0_ready = gnt_s[REQ_EXU];
    assign wb1_ready = gnt_s[REQ_LSU];
    assign hs_s      = |gnt_s;

    // busy[0] is never set, so x0 always reads as free / reservable.
    assign rsv_ready = ~busy_r[rsv_addr];
    assign rs1_busy  = busy_r[rs1_addr];
    assign rs2_busy  = busy_r[rs2_addr];

    // Granted requester's address and data feed the write register.
    always_comb begin
        sel_addr_s = wb0_addr;
        sel_data_s = wb0_data;
        if (gnt_s[REQ_LSU]) begin
            sel_addr_s = wb1_addr;
            sel_data_s = wb1_data;
        end else begin
            sel_addr_s = wb0_addr;
            sel_data_s = wb0_data;
        end
    end

    // Scoreboard next state: clear on file write, then set so a reservation wins.
    always_comb begin
        rsv_fire_s  = rsv_valid & rsv_ready & (rsv_addr != ZERO_ADDR);
        clr_mask_s  = rf_wen ? (NREG'(1) << rf_waddr) : '0;
        set_mask_s  = rsv_fire_s ? (NREG'(1) << rsv_addr) : '0;
        busy_next_s = (busy_r & ~clr_mask_s) | set_mask_s;
    end

    // Busy scoreboard register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_r <= '0;
        end else begin
            busy_r <= busy_next_s;
        end
    end

    // Write stage: one cycle after the handshake; writes to x0 are swallowed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_wen   <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else if (hs_s) begin
            rf_wen   <= (sel_addr_s != ZERO_ADDR);
            rf_waddr <= sel_addr_s;
            rf_wdata <= sel_data_s;
        end else begin
            rf_wen   <= 1'b0;
            rf_waddr <= rf_waddr;
            rf_wdata <= rf_wdata;
        end
    end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed table-driven bench for regfile_wb_arbiter plus an async-reset sequence.
module tb_regfile_wb_arbiter;
    logic        clk;
    logic        rst;
    logic        wb0_valid, wb0_ready, wb1_valid, wb1_ready;
    logic [4:0]  wb0_addr, wb1_addr, rsv_addr, rs1_addr, rs2_addr, rf_waddr;
    logic [31:0] wb0_data, wb1_data, rf_wdata;
    logic        rsv_valid, rsv_ready, rs1_busy, rs2_busy, rf_wen;

    int checks = 0;
    int errors = 0;

    regfile_wb_arbiter dut (
        .clk(clk), .rst(rst),
        .wb0_valid(wb0_valid), .wb0_ready(wb0_ready), .wb0_addr(wb0_addr), .wb0_data(wb0_data),
        .wb1_valid(wb1_valid), .wb1_ready(wb1_ready), .wb1_addr(wb1_addr), .wb1_data(wb1_data),
        .rsv_valid(rsv_valid), .rsv_addr(rsv_addr), .rsv_ready(rsv_ready),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        w0v; logic [4:0] w0a; logic [31:0] w0d;
        logic        w1v; logic [4:0] w1a; logic [31:0] w1d;
        logic        rv;  logic [4:0] ra;  logic [4:0] r1; logic [4:0] r2;
        logic        e_w0r, e_w1r, e_rr, e_b1, e_b2, e_wen;
        logic [4:0]  e_waddr; logic [31:0] e_wdata; logic chk_bus;
    } row_t;

    localparam int NROWS = 21;
    row_t vec [NROWS];

    function automatic row_t r(
        input logic w0v, input logic [4:0] w0a, input logic [31:0] w0d,
        input logic w1v, input logic [4:0] w1a, input logic [31:0] w1d,
        input logic rv, input logic [4:0] ra, input logic [4:0] r1, input logic [4:0] r2,
        input logic ew0, input logic ew1, input logic err, input logic eb1, input logic eb2,
        input logic ewen, input logic [4:0] ewa, input logic [31:0] ewd, input logic chk);
        row_t t;
        t.w0v = w0v; t.w0a = w0a; t.w0d = w0d;
        t.w1v = w1v; t.w1a = w1a; t.w1d = w1d;
        t.rv = rv; t.ra = ra; t.r1 = r1; t.r2 = r2;
        t.e_w0r = ew0; t.e_w1r = ew1; t.e_rr = err; t.e_b1 = eb1; t.e_b2 = eb2;
        t.e_wen = ewen; t.e_waddr = ewa; t.e_wdata = ewd; t.chk_bus = chk;
        return t;
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0d: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input row_t t);
        wb0_valid = t.w0v; wb0_addr = t.w0a; wb0_data = t.w0d;
        wb1_valid = t.w1v; wb1_addr = t.w1a; wb1_data = t.w1d;
        rsv_valid = t.rv;  rsv_addr = t.ra;  rs1_addr = t.r1; rs2_addr = t.r2;
    endtask

    initial begin
        // contention from reset: grants 0,1,0 -> waddr 1,2,1
        vec[0]  = r(1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0,    1'b1);
        vec[1]  = r(1'b1, 5'd1, 32'h11,   1'b1, 5'd2, 32'h22,   1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0,    1'b1);
        vec[2]  = r(1'b1, 5'd1, 32'h11,   1'b1, 5'd2, 32'h22,   1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 5'd1, 32'h11,   1'b1);
        vec[3]  = r(1'b1, 5'd1, 32'h11,   1'b1, 5'd2, 32'h22,   1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd2, 32'h22,   1'b1);
        vec[4]  = r(1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd1, 32'h11,   1'b1);
        // single EXU write to r5
        vec[5]  = r(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd1, 32'h11,   1'b1);
        vec[6]  = r(1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd5, 32'h1234, 1'b1);
        vec[7]  = r(1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd5, 32'h1234, 1'b1);
        // scoreboard lifecycle on r7
        vec[8]  = r(1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,    1'b1, 5'd7, 5'd7, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd5, 32'h1234, 1'b1);
        vec[9]  = r(1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,    1'b1, 5'd7, 5'd7, 5'd7, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd5, 32'h1234, 1'b1);
        vec[10] = r(1'b0, 5'd0, 32'h0,    1'b1, 5'd7, 32'hBEEF, 1'b0, 5'd0, 5'd7, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd5, 32'h1234, 1'b1);
        vec[11] = r(1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 5'd7, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 5'd7, 32'hBEEF, 1'b1);
        vec[12] = r(1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 5'd7, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd7, 32'hBEEF, 1'b1);
        // x0: reserve never sticks, write is accepted but not performed
        vec[13] = r(1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,    1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd7, 32'hBEEF, 1'b1);
        vec[14] = r(1'b0, 5'd0, 32'h0,    1'b1, 5'd0, 32'hFFFF, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd7, 32'hBEEF, 1'b1);
        vec[15] = r(1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0,    1'b0);
        // set/clear collision on r3: rejected during rf_wen, accepted on retry
        vec[16] = r(1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,    1'b1, 5'd3, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0,    1'b0);
        vec[17] = r(1'b1, 5'd3, 32'h3333, 1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 5'd3, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0,    1'b0);
        vec[18] = r(1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,    1'b1, 5'd3, 5'd3, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd3, 32'h3333, 1'b1);
        vec[19] = r(1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,    1'b1, 5'd3, 5'd3, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd3, 32'h3333, 1'b1);
        vec[20] = r(1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,    1'b0, 5'd3, 5'd3, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd3, 32'h3333, 1'b1);

        rst = 1'b1;
        drive(vec[0]);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < NROWS; i++) begin
            if (i != 0) @(negedge clk);
            drive(vec[i]);
            #1;
            check("wb0_ready", i, 32'(wb0_ready), 32'(vec[i].e_w0r));
            check("wb1_ready", i, 32'(wb1_ready), 32'(vec[i].e_w1r));
            check("rsv_ready", i, 32'(rsv_ready), 32'(vec[i].e_rr));
            check("rs1_busy",  i, 32'(rs1_busy),  32'(vec[i].e_b1));
            check("rs2_busy",  i, 32'(rs2_busy),  32'(vec[i].e_b2));
            check("rf_wen",    i, 32'(rf_wen),    32'(vec[i].e_wen));
            if (vec[i].chk_bus) begin
                check("rf_waddr", i, 32'(rf_waddr), 32'(vec[i].e_waddr));
                check("rf_wdata", i, rf_wdata, vec[i].e_wdata);
            end
        end

        // Async reset with a write in flight, busy[4] set and prio pointing at LSU.
        @(negedge clk);
        drive(r(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 5'd4, 5'd3,
                1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0));
        @(negedge clk);
        drive(r(1'b1, 5'd4, 32'h4444, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd4, 5'd3,
                1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0));
        #1;
        check("rst_seq_wb0_ready", 100, 32'(wb0_ready), 32'd1);
        @(negedge clk);
        wb0_valid = 1'b0;
        #1;
        check("pre_rst_wen",   101, 32'(rf_wen),   32'd1);
        check("pre_rst_waddr", 101, 32'(rf_waddr), 32'd4);
        check("pre_rst_busy4", 101, 32'(rs1_busy), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        check("rst_wen",   102, 32'(rf_wen),   32'd0);
        check("rst_waddr", 102, 32'(rf_waddr), 32'd0);
        check("rst_wdata", 102, rf_wdata,      32'd0);
        check("rst_busy4", 102, 32'(rs1_busy), 32'd0);
        check("rst_busy3", 102, 32'(rs2_busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        wb0_valid = 1'b1; wb0_addr = 5'd1; wb0_data = 32'hA;
        wb1_valid = 1'b1; wb1_addr = 5'd2; wb1_data = 32'hB;
        #1;
        check("rst_prio_wb0", 103, 32'(wb0_ready), 32'd1);
        check("rst_prio_wb1", 103, 32'(wb1_ready), 32'd0);
        @(negedge clk);
        wb0_valid = 1'b0; wb1_valid = 1'b0;
        #1;
        check("post_rst_wen",   104, 32'(rf_wen),   32'd1);
        check("post_rst_waddr", 104, 32'(rf_waddr), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
